// File: rtl/lsu_ecc_scrub_if.sv
// DCCM write-port bundle between the ECC scrubber and the DCCM write arbiter.
//   scrub_wr_req  : scrubber has a corrected word pending
//   scrub_wr_addr : word-aligned DCCM byte address of that word
//   scrub_wr_data : corrected data
//   scrub_wr_ecc  : re-encoded ECC for scrub_wr_data
//   scrub_wr_gnt  : arbiter grants the write port to the scrubber this cycle
// master = scrubber side, slave = arbiter side.
interface lsu_ecc_scrub_if #(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7
);
  logic                       scrub_wr_req;
  logic [DCCM_BITS-1:0]       scrub_wr_addr;
  logic [DCCM_DATA_WIDTH-1:0] scrub_wr_data;
  logic [DCCM_ECC_WIDTH-1:0]  scrub_wr_ecc;
  logic                       scrub_wr_gnt;

  modport master (
    output scrub_wr_req, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc,
    input  scrub_wr_gnt
  );

  modport slave (
    input  scrub_wr_req, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc,
    output scrub_wr_gnt
  );
endinterface

// File: rtl/lsu_ecc_scrub.sv
// Load-path ECC scrubber for the DCCM.
// Captures SEC-corrected dc3 load data per bank, re-encodes it, holds it in a
// 2-entry FIFO and writes it back through the DCCM write-port req/gnt handshake.
// Store-buffer drains to a queued word invalidate that entry (drain data is newer).
//
// Optional feature macro: RV_LSU_ECC_SCRUB_CNT_EN
//   defined   : scrub_cnt counts granted writes, saturating; scrub_cnt_clr wins.
//   undefined : scrub_cnt is 0 and scrub_cnt_clr is ignored.
//
// Ports:
//   clk, rst_l                     core clock, async active-low reset
//   ecc_chk_vld_dc3, flush_dc3     dc3 ECC-checked load / kill
//   single_ecc_error_{hi,lo}_dc3   SEC per bank
//   lsu_double_ecc_error_dc3       DED on either bank
//   lsu_addr_dc3, end_addr_dc3     lo / hi bank byte addresses
//   store_ecc_datafn_{hi,lo}_dc3   corrected bank data
//   stbuf_wr_vld, stbuf_wr_addr    store-buffer drain write
//   scrub_cnt_clr                  clear completed-scrub counter
//   wr_if (master)                 write-back req/addr/data/ecc, gnt
//   scrub_full, scrub_drop         queue full, registered drop pulse
//   scrub_cnt                      completed-scrub counter

module rvecc_encode (
  input  logic [31:0] din,
  output logic [6:0]  ecc_out
);
  // Hamming(38,32): data occupies non-power-of-two positions 1..38,
  // check bit k covers positions with bit k set; bit 6 is overall parity.
  always_comb begin
    int unsigned j;
    ecc_out = '0;
    j = 0;
    for (int unsigned p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int unsigned k = 0; k < 6; k++) begin
          if (p[k]) ecc_out[k] = ecc_out[k] ^ din[j[4:0]];
        end
        j = j + 1;
      end
    end
    ecc_out[6] = ^{din, ecc_out[5:0]};
  end
endmodule

module lsu_ecc_scrub #(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       ecc_chk_vld_dc3,
  input  logic                       flush_dc3,
  input  logic                       single_ecc_error_hi_dc3,
  input  logic                       single_ecc_error_lo_dc3,
  input  logic                       lsu_double_ecc_error_dc3,
  input  logic [DCCM_BITS-1:0]       lsu_addr_dc3,
  input  logic [DCCM_BITS-1:0]       end_addr_dc3,
  input  logic [DCCM_DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3,
  input  logic [DCCM_DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3,
  input  logic                       stbuf_wr_vld,
  input  logic [DCCM_BITS-1:0]       stbuf_wr_addr,
  input  logic                       scrub_cnt_clr,
  lsu_ecc_scrub_if.master            wr_if,
  output logic                       scrub_full,
  output logic                       scrub_drop,
  output logic [15:0]                scrub_cnt
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 valid_q, valid_d;
  logic [DCCM_BITS-1:0]       addr_q [2];
  logic [DCCM_BITS-1:0]       addr_d [2];
  logic [DCCM_DATA_WIDTH-1:0] data_q [2];
  logic [DCCM_DATA_WIDTH-1:0] data_d [2];
  logic [DCCM_ECC_WIDTH-1:0]  ecc_q  [2];
  logic [DCCM_ECC_WIDTH-1:0]  ecc_d  [2];
  logic                       head_q, head_d, tail_q, tail_d;
  logic [1:0]                 count_q, count_d;
  logic                       drop_q, drop_d;

  logic [DCCM_ECC_WIDTH-1:0]  ecc_lo, ecc_hi;
  logic                       head_vld, cap, cap_lo, cap_hi, pop, enq_lo, enq_hi, slot_hi;
  logic [1:0]                 free;
  logic [DCCM_BITS-1:0]       addr_lo, addr_hi;

  rvecc_encode u_enc_lo (.din(store_ecc_datafn_lo_dc3), .ecc_out(ecc_lo));
  rvecc_encode u_enc_hi (.din(store_ecc_datafn_hi_dc3), .ecc_out(ecc_hi));

  assign addr_lo = {lsu_addr_dc3[DCCM_BITS-1:2], 2'b00};
  assign addr_hi = {end_addr_dc3[DCCM_BITS-1:2], 2'b00};

  always_comb begin
    head_vld = valid_q[head_q];
    cap      = ecc_chk_vld_dc3 & ~flush_dc3 & ~lsu_double_ecc_error_dc3;
    cap_lo   = cap & single_ecc_error_lo_dc3;
    cap_hi   = cap & single_ecc_error_hi_dc3;
    // An invalidated head leaves without a request; a valid head needs gnt.
    pop      = (state_q == REQ) & (~head_vld | wr_if.scrub_wr_gnt);
    // Slots free once this cycle's pop has left (pop implies count>0).
    free     = 2'd2 - count_q + {1'b0, pop};
    enq_lo   = cap_lo & (free != 2'd0);
    enq_hi   = cap_hi & (free > {1'b0, enq_lo});
    drop_d   = (cap_lo & ~enq_lo) | (cap_hi & ~enq_hi);

    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ecc_d    = ecc_q;
    head_d   = head_q;
    // Order matters: hazard clear, then pop, then enqueue, so a slot freed
    // by the pop in a full queue can be refilled in the same cycle.
    for (int unsigned i = 0; i < 2; i++) begin
      if (stbuf_wr_vld && valid_q[i] &&
          addr_q[i][DCCM_BITS-1:2] == stbuf_wr_addr[DCCM_BITS-1:2])
        valid_d[i] = 1'b0;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ~head_q;
    end
    if (enq_lo) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = addr_lo;
      data_d[tail_q]  = store_ecc_datafn_lo_dc3;
      ecc_d[tail_q]   = ecc_lo;
    end
    slot_hi = tail_q ^ enq_lo;
    if (enq_hi) begin
      valid_d[slot_hi] = 1'b1;
      addr_d[slot_hi]  = addr_hi;
      data_d[slot_hi]  = store_ecc_datafn_hi_dc3;
      ecc_d[slot_hi]   = ecc_hi;
    end
    tail_d  = tail_q ^ enq_lo ^ enq_hi;
    count_d = count_q - {1'b0, pop} + {1'b0, enq_lo} + {1'b0, enq_hi};

    state_d = state_q;
    case (state_q)
      IDLE:    if (enq_lo | enq_hi) state_d = REQ;
      REQ:     if (count_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      ecc_q   <= '{default: '0};
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ecc_q   <= ecc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign wr_if.scrub_wr_req  = valid_q[head_q];
  assign wr_if.scrub_wr_addr = addr_q[head_q];
  assign wr_if.scrub_wr_data = data_q[head_q];
  assign wr_if.scrub_wr_ecc  = ecc_q[head_q];
  assign scrub_full          = (count_q == 2'd2);
  assign scrub_drop          = drop_q;

`ifdef RV_LSU_ECC_SCRUB_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                                   cnt_q <= '0;
    else if (scrub_cnt_clr)                       cnt_q <= '0;
    else if (wr_if.scrub_wr_req && wr_if.scrub_wr_gnt && cnt_q != '1)
                                                  cnt_q <= cnt_q + 16'd1;
  end
  assign scrub_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = scrub_cnt_clr;
  assign scrub_cnt      = '0;
`endif

  a_gnt_vs_drain: assert property (@(posedge clk) disable iff (!rst_l)
    !(wr_if.scrub_wr_gnt && stbuf_wr_vld));
  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_l)
    wr_if.scrub_wr_gnt |-> wr_if.scrub_wr_req);

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
module tb_lsu_ecc_scrub;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        ecc_chk_vld_dc3, flush_dc3, single_ecc_error_hi_dc3, single_ecc_error_lo_dc3;
  logic        lsu_double_ecc_error_dc3, stbuf_wr_vld, scrub_cnt_clr;
  logic [15:0] lsu_addr_dc3, end_addr_dc3, stbuf_wr_addr;
  logic [31:0] store_ecc_datafn_hi_dc3, store_ecc_datafn_lo_dc3;
  logic        scrub_full, scrub_drop;
  logic [15:0] scrub_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  lsu_ecc_scrub_if #(.DCCM_BITS(16), .DCCM_DATA_WIDTH(32), .DCCM_ECC_WIDTH(7)) wr_if ();

  lsu_ecc_scrub #(.DCCM_BITS(16), .DCCM_DATA_WIDTH(32), .DCCM_ECC_WIDTH(7)) dut (
    .clk(clk), .rst_l(rst_l),
    .ecc_chk_vld_dc3(ecc_chk_vld_dc3), .flush_dc3(flush_dc3),
    .single_ecc_error_hi_dc3(single_ecc_error_hi_dc3),
    .single_ecc_error_lo_dc3(single_ecc_error_lo_dc3),
    .lsu_double_ecc_error_dc3(lsu_double_ecc_error_dc3),
    .lsu_addr_dc3(lsu_addr_dc3), .end_addr_dc3(end_addr_dc3),
    .store_ecc_datafn_hi_dc3(store_ecc_datafn_hi_dc3),
    .store_ecc_datafn_lo_dc3(store_ecc_datafn_lo_dc3),
    .stbuf_wr_vld(stbuf_wr_vld), .stbuf_wr_addr(stbuf_wr_addr),
    .scrub_cnt_clr(scrub_cnt_clr), .wr_if(wr_if),
    .scrub_full(scrub_full), .scrub_drop(scrub_drop), .scrub_cnt(scrub_cnt)
  );

  always #5 clk = ~clk;

  // Reference ECC: build the 38-bit Hamming codeword, then XOR per check bit.
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  e;
    int          j;
    cw = '0; e = '0; j = 0;
    for (int p = 1; p <= 38; p++)
      if (!$onehot(p)) begin cw[p] = d[j]; j++; end
    for (int k = 0; k < 6; k++)
      for (int p = 1; p <= 38; p++)
        if (((p >> k) & 1) == 1) e[k] = e[k] ^ cw[p];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of pending words.
  typedef struct { bit v; logic [15:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  bit          m_drop;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q.delete(); m_drop = 1'b0; m_cnt = '0;
    end else begin
      bit   cap, pop, granted;
      ent_t e;
      cap     = ecc_chk_vld_dc3 && !flush_dc3 && !lsu_double_ecc_error_dc3;
      pop     = (q.size() > 0) && (!q[0].v || wr_if.scrub_wr_gnt);
      granted = pop && q[0].v && wr_if.scrub_wr_gnt;
      foreach (q[i])
        if (stbuf_wr_vld && q[i].v && q[i].a[15:2] == stbuf_wr_addr[15:2]) q[i].v = 1'b0;
      if (pop) void'(q.pop_front());
      m_drop = 1'b0;
      if (cap && single_ecc_error_lo_dc3) begin
        e.v = 1'b1; e.a = lsu_addr_dc3 & 16'hFFFC; e.d = store_ecc_datafn_lo_dc3;
        if (q.size() < 2) q.push_back(e); else m_drop = 1'b1;
      end
      if (cap && single_ecc_error_hi_dc3) begin
        e.v = 1'b1; e.a = end_addr_dc3 & 16'hFFFC; e.d = store_ecc_datafn_hi_dc3;
        if (q.size() < 2) q.push_back(e); else m_drop = 1'b1;
      end
`ifdef RV_LSU_ECC_SCRUB_CNT_EN
      if (scrub_cnt_clr) m_cnt = '0;
      else if (granted && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end
  end

  function automatic bit m_req();
    return (q.size() > 0) && q[0].v;
  endfunction

  // Single compare process against the model.
  always @(negedge clk) begin
    if (rst_l && chk_en) begin
      chk("req", wr_if.scrub_wr_req, m_req());
      if (m_req()) begin
        chk("addr", wr_if.scrub_wr_addr, q[0].a);
        chk("data", wr_if.scrub_wr_data, q[0].d);
        chk("ecc",  wr_if.scrub_wr_ecc,  ref_ecc(q[0].d));
      end
      chk("full", scrub_full, q.size() == 2);
      chk("drop", scrub_drop, m_drop);
      chk("cnt",  scrub_cnt,  m_cnt);
    end
  end

  task automatic idle();
    ecc_chk_vld_dc3 = 0; flush_dc3 = 0; single_ecc_error_hi_dc3 = 0;
    single_ecc_error_lo_dc3 = 0; lsu_double_ecc_error_dc3 = 0;
    stbuf_wr_vld = 0; scrub_cnt_clr = 0; wr_if.scrub_wr_gnt = 0;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] ea, input bit lo, input bit hi,
                      input logic [31:0] dlo, input logic [31:0] dhi);
    ecc_chk_vld_dc3 = 1; single_ecc_error_lo_dc3 = lo; single_ecc_error_hi_dc3 = hi;
    lsu_addr_dc3 = a; end_addr_dc3 = ea;
    store_ecc_datafn_lo_dc3 = dlo; store_ecc_datafn_hi_dc3 = dhi;
  endtask

  initial begin
    idle();
    lsu_addr_dc3 = '0; end_addr_dc3 = '0; stbuf_wr_addr = '0;
    store_ecc_datafn_hi_dc3 = '0; store_ecc_datafn_lo_dc3 = '0;

    // Model pins for the encoder.
    chk("pin_ecc0", ref_ecc(32'h0), 7'h00);
    chk("pin_ecc1", ref_ecc(32'h1), 7'h43);
    chk("pin_ecc2", ref_ecc(32'h2), 7'h45);

    #12;
    chk("rst_req", wr_if.scrub_wr_req, 1'b0);
    chk("rst_full", scrub_full, 1'b0);
    chk("rst_cnt", scrub_cnt, 16'h0);
    @(negedge clk); rst_l = 1'b1; chk_en = 1'b1;
    step();

    // Lo-only SEC.
    load(16'h0104, 16'h0107, 1, 0, 32'hDEADBEEF, 32'h0);
    step(); idle();
    chk("lo_req", wr_if.scrub_wr_req, 1'b1);
    chk("lo_addr", wr_if.scrub_wr_addr, 16'h0104);
    chk("lo_data", wr_if.scrub_wr_data, 32'hDEADBEEF);
    wr_if.scrub_wr_gnt = 1;
    step(); idle();
    chk("lo_req_after_gnt", wr_if.scrub_wr_req, 1'b0);
`ifdef RV_LSU_ECC_SCRUB_CNT_EN
    chk("lo_cnt", scrub_cnt, 16'd1);
`endif

    // Encoder on the DUT path with a hand-computed value.
    load(16'h0020, 16'h0023, 1, 0, 32'h1, 32'h0);
    step(); idle();
    chk("ecc_one", wr_if.scrub_wr_ecc, 7'h43);
    wr_if.scrub_wr_gnt = 1; step(); idle();

    // Dual-bank, gnt held.
    load(16'h0106, 16'h0109, 1, 1, 32'h11111111, 32'h22222222);
    step(); idle(); wr_if.scrub_wr_gnt = 1;
    chk("dual_addr0", wr_if.scrub_wr_addr, 16'h0104);
    chk("dual_full0", scrub_full, 1'b1);
    step();
    chk("dual_addr1", wr_if.scrub_wr_addr, 16'h0108);
    chk("dual_data1", wr_if.scrub_wr_data, 32'h22222222);
    chk("dual_full1", scrub_full, 1'b0);
    step(); idle();
    chk("dual_done", wr_if.scrub_wr_req, 1'b0);

    // DED and flush suppress capture.
    load(16'h0140, 16'h0143, 1, 1, 32'h5, 32'h6); lsu_double_ecc_error_dc3 = 1;
    step(); idle();
    chk("ded_req", wr_if.scrub_wr_req, 1'b0);
    load(16'h0140, 16'h0143, 1, 1, 32'h5, 32'h6); flush_dc3 = 1;
    step(); idle();
    chk("flush_req", wr_if.scrub_wr_req, 1'b0);
    chk("flush_full", scrub_full, 1'b0);

    // Overflow: two pending, then a third SEC.
    load(16'h0106, 16'h0109, 1, 1, 32'hAAAA0000, 32'hBBBB0000);
    step(); idle();
    load(16'h0180, 16'h0183, 1, 0, 32'hCCCC0000, 32'h0);
    step(); idle();
    chk("ovf_drop", scrub_drop, 1'b1);
    chk("ovf_addr", wr_if.scrub_wr_addr, 16'h0104);
    chk("ovf_full", scrub_full, 1'b1);
    step();
    chk("ovf_drop_pulse", scrub_drop, 1'b0);
    wr_if.scrub_wr_gnt = 1; step(); step(); idle();

    // Store-buffer hazard.
    load(16'h0200, 16'h0203, 1, 0, 32'h0BADF00D, 32'h0);
    step(); idle();
    chk("haz_req_before", wr_if.scrub_wr_req, 1'b1);
    stbuf_wr_vld = 1; stbuf_wr_addr = 16'h0202;
    step(); idle();
    chk("haz_req_after", wr_if.scrub_wr_req, 1'b0);
    step();
    chk("haz_empty", scrub_full, 1'b0);

    // Async reset with req high.
    load(16'h0300, 16'h0303, 1, 0, 32'h12345678, 32'h0);
    step(); idle();
    chk("ar_req_before", wr_if.scrub_wr_req, 1'b1);
    #2 rst_l = 1'b0;
    #1;
    chk("ar_req", wr_if.scrub_wr_req, 1'b0);
    chk("ar_addr", wr_if.scrub_wr_addr, 16'h0);
    chk("ar_data", wr_if.scrub_wr_data, 32'h0);
    chk("ar_ecc", wr_if.scrub_wr_ecc, 7'h0);
    chk("ar_cnt", scrub_cnt, 16'h0);
    @(negedge clk); rst_l = 1'b1;
    step(); step();
    chk("ar_no_req", wr_if.scrub_wr_req, 1'b0);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      idle();
      ecc_chk_vld_dc3          = ($urandom_range(0, 9) < 6);
      flush_dc3                = ($urandom_range(0, 9) == 0);
      lsu_double_ecc_error_dc3 = ($urandom_range(0, 9) == 0);
      single_ecc_error_lo_dc3  = $urandom_range(0, 1);
      single_ecc_error_hi_dc3  = $urandom_range(0, 1);
      lsu_addr_dc3             = 16'h0100 + 16'($urandom_range(0, 31));
      end_addr_dc3             = lsu_addr_dc3 + 16'd3;
      store_ecc_datafn_lo_dc3  = $urandom;
      store_ecc_datafn_hi_dc3  = $urandom;
      stbuf_wr_vld             = ($urandom_range(0, 5) == 0);
      stbuf_wr_addr            = 16'h0100 + 16'($urandom_range(0, 39));
      scrub_cnt_clr            = ($urandom_range(0, 49) == 0);
      wr_if.scrub_wr_gnt       = m_req() && !stbuf_wr_vld && ($urandom_range(0, 2) != 0);
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ecc_scrub.md
# lsu_ecc_scrub

Load-path ECC scrubber for the DCCM. It captures SEC-corrected load data from the dc3 ECC decode stage, re-encodes it, and queues it in a 2-entry buffer. It writes the corrected word back to the DCCM bank through a req/gnt handshake with the DCCM write-port arbiter, so a single-bit error is not reported again on the next access. It sits directly downstream of the dc3 ECC check and in parallel with store-buffer drain on the DCCM write port.

## Interface
- DCCM_BITS, 16, DCCM byte-address width
- DCCM_DATA_WIDTH, 32, bank data width
- DCCM_ECC_WIDTH, 7, bank ECC width
- clk  in  1  core clock
- rst_l  in  1  reset, asynchronous, active-low
- ecc_chk_vld_dc3  in  1  dc3 load in DCCM with ECC check enabled
- flush_dc3  in  1  kill of the dc3 instruction
- single_ecc_error_hi_dc3 / _lo_dc3  in  1  SEC detected per bank
- lsu_double_ecc_error_dc3  in  1  DED on either bank
- lsu_addr_dc3, end_addr_dc3  in  DCCM_BITS  start/end byte address (lo bank word / hi bank word)
- store_ecc_datafn_hi_dc3 / _lo_dc3  in  DCCM_DATA_WIDTH  corrected bank data
- stbuf_wr_vld  in  1  store-buffer drain writing DCCM this cycle
- stbuf_wr_addr  in  DCCM_BITS  drain address
- scrub_wr_gnt  in  1  write port granted to scrubber
- scrub_cnt_clr  in  1  clear error counter
- scrub_wr_req  out  1  pending write-back
- scrub_wr_addr  out  DCCM_BITS  word-aligned write address ([1:0]=0)
- scrub_wr_data  out  DCCM_DATA_WIDTH  corrected data
- scrub_wr_ecc  out  DCCM_ECC_WIDTH  re-encoded ECC
- scrub_full  out  1  count==2
- scrub_drop  out  1  one-cycle pulse: capture lost for lack of space
- scrub_cnt  out  16  completed-scrub counter

## Operation
- Capture qualifier: cap = ecc_chk_vld_dc3 & ~flush_dc3 & ~lsu_double_ecc_error_dc3. Lo entry needs cap & single_lo. Hi entry needs cap & single_hi.
- Entry = {valid, word addr, data, ecc}. ECC is computed at capture by an rvecc_encode instance on the incoming data and stored.
- Lo addr = lsu_addr_dc3 with [1:0] cleared. Hi addr = end_addr_dc3 with [1:0] cleared.
- FIFO of 2 entries: head/tail pointers of 1 bit each, count 0..2.
- When lo and hi capture in the same cycle, lo is enqueued first.
- An entry enqueues only if a slot is free after this cycle's pop. An entry with no slot is dropped and scrub_drop pulses. With count==2 and no pop, both are dropped.
- Pop when head valid & scrub_wr_gnt.
- Hazard: stbuf_wr_vld with stbuf_wr_addr[DCCM_BITS-1:2] matching a valid entry clears that entry's valid bit; the drain data is newer.
- An invalidated head is popped silently the next cycle with no request. The counter is not incremented.
- FSM with two states:
  - IDLE: count==0. Moves to REQ when an entry enqueues.
  - REQ: count>0. Returns to IDLE when the last entry pops or is discarded with no enqueue.
- scrub_wr_req = head valid (combinational from flops). scrub_wr_addr/data/ecc come from the head entry and stay stable until gnt.
- Outputs reset to 0: scrub_wr_req, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc, scrub_full, scrub_drop, scrub_cnt. All entry valid bits and pointers reset to 0, state resets to IDLE.
- Assertion: scrub_wr_gnt and stbuf_wr_vld are never high in the same cycle. Gnt without req is illegal.

## Timing
- Capture on the clk edge ending dc3 (cycle N). scrub_wr_req rises in N+1.
- If gnt arrives in N+1, the write occurs in N+1 and the next entry's req is visible in N+2. Minimum of 1 cycle per scrub.
- Simultaneous enqueue and pop are supported. Count is unchanged with one in and one out.
- An invalidation in cycle M drops req in M+1.
- scrub_drop is registered: it pulses in N+1 for a dc3 drop in N.
- Asynchronous reset mid-request drops all pending entries immediately. No write is issued after reset.

## Configuration
- RV_LSU_ECC_SCRUB_CNT_EN defined:
  - scrub_cnt is a 16-bit counter that increments on each granted write and saturates at 0xFFFF.
  - scrub_cnt_clr has priority over increment.
- Not defined: scrub_cnt is tied to 0, scrub_cnt_clr is ignored, and the counter flops are removed.

## Test plan
- Lo-only SEC at lsu_addr_dc3=0x0104, data 0xDEADBEEF → req in next cycle, addr 0x0104, data 0xDEADBEEF, ecc = encode(0xDEADBEEF). Gnt → req low next cycle, scrub_cnt=1.
- Dual-bank load at addr 0x0106/end 0x0109 with SEC on both, gnt held high → two writes in consecutive cycles: 0x0104 (lo) then 0x0108 (hi). scrub_full=1 for one cycle.
- SEC with lsu_double_ecc_error_dc3=1, or with flush_dc3=1 → no req, count stays 0.
- Two pending entries and gnt low, then a third SEC → scrub_drop pulses once and the queue is unchanged.
- Entry pending at 0x0200 plus stbuf_wr_vld at 0x0202 → entry discarded, req low within 1 cycle, scrub_cnt unchanged.
- rst_l asserted with req high → all outputs 0 asynchronously. After release, no req without a new capture.
